// File: rtl/ctrl_pkg.sv
// ============================================================================
// Module   : ctrl_pkg
// Purpose  : Opcodes, ALU classes and the control bundle shared by ctrl_pipe.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [1:0] ALUOP_RTYPE = 2'b00;
    localparam logic [1:0] ALUOP_ITYPE = 2'b01;
    localparam logic [1:0] ALUOP_MEM   = 2'b10;
    localparam logic [1:0] ALUOP_JUMP  = 2'b11;

    typedef struct packed {
        logic       jalr;
        logic       jal;
        logic       branch;
        logic       memread;
        logic       memtoreg;
        logic       memwrite;
        logic       alusrc;
        logic       regwrite;
        logic [1:0] aluop;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

`default_nettype wire

// File: rtl/ctrl_decode.sv
// ============================================================================
// Module   : ctrl_decode
// Purpose  : Combinational opcode -> control bundle table and rs usage flags.
//            Mul/div recognition is present only when CTRL_MULDIV_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic       valid,
    input  logic [6:0] opcode,
    input  logic [6:0] funct7,
    output ctrl_t      ctrl,
    output logic       md,
    output logic       use_rs1,
    output logic       use_rs2
);

    always_comb begin
        ctrl    = CTRL_BUBBLE;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        if (valid) begin
            case (opcode)
                OP_R: begin
                    ctrl.regwrite = 1'b1;
                    ctrl.aluop    = ALUOP_RTYPE;
                    use_rs1       = 1'b1;
                    use_rs2       = 1'b1;
                end
                OP_I: begin
                    ctrl.alusrc   = 1'b1;
                    ctrl.regwrite = 1'b1;
                    ctrl.aluop    = ALUOP_ITYPE;
                    use_rs1       = 1'b1;
                end
                OP_LOAD: begin
                    ctrl.memread  = 1'b1;
                    ctrl.memtoreg = 1'b1;
                    ctrl.alusrc   = 1'b1;
                    ctrl.regwrite = 1'b1;
                    ctrl.aluop    = ALUOP_MEM;
                    use_rs1       = 1'b1;
                end
                OP_STORE: begin
                    ctrl.memwrite = 1'b1;
                    ctrl.alusrc   = 1'b1;
                    ctrl.aluop    = ALUOP_MEM;
                    use_rs1       = 1'b1;
                    use_rs2       = 1'b1;
                end
                OP_BRANCH: begin
                    ctrl.branch   = 1'b1;
                    use_rs1       = 1'b1;
                    use_rs2       = 1'b1;
                end
                OP_JAL: begin
                    ctrl.jal      = 1'b1;
                    ctrl.regwrite = 1'b1;
                    ctrl.aluop    = ALUOP_JUMP;
                end
                OP_JALR: begin
                    ctrl.jalr     = 1'b1;
                    ctrl.alusrc   = 1'b1;
                    ctrl.regwrite = 1'b1;
                    ctrl.aluop    = ALUOP_JUMP;
                    use_rs1       = 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef CTRL_MULDIV_EN
    assign md = valid && (opcode == OP_R) && (funct7 == F7_MULDIV);
`else
    logic w_unused_funct7;
    assign w_unused_funct7 = ^funct7;
    assign md              = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/ctrl_pipe.sv
// ============================================================================
// Module   : ctrl_pipe
// Purpose  : RV32I pipelined control: decode, EX/MEM/WB control registers,
//            load-use bubbles, redirect flush, memory-stall freeze.
//            Optional multi-cycle mul/div occupancy under CTRL_MULDIV_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int MD_LATENCY = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [6:0]        id_opcode,
    input  logic [6:0]        id_funct7,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              ex_redirect,
    input  logic              mem_stall,
    output logic              stall_id,
    output logic              id_flush,
    output logic              ex_jalr,
    output logic              ex_jal,
    output logic              ex_branch,
    output logic              ex_memread,
    output logic              ex_memtoreg,
    output logic              ex_memwrite,
    output logic              ex_alusrc,
    output logic              ex_regwrite,
    output logic [1:0]        ex_aluop,
    output logic              ex_md,
    output logic [REG_AW-1:0] ex_rd,
    output logic              mem_memread,
    output logic              mem_memwrite,
    output logic              mem_memtoreg,
    output logic              mem_regwrite,
    output logic [REG_AW-1:0] mem_rd,
    output logic              wb_memtoreg,
    output logic              wb_regwrite,
    output logic [REG_AW-1:0] wb_rd,
    output logic              md_busy
);

    ctrl_t             w_id_ctrl;
    logic              w_id_md;
    logic              w_use_rs1;
    logic              w_use_rs2;
    logic [REG_AW-1:0] w_id_rd;
    logic              w_load_use;
    logic              w_ex_bubble;
    logic              w_md_busy;

    ctrl_t             r_ex_ctrl;
    logic              r_ex_md;
    logic [REG_AW-1:0] r_ex_rd;
    logic              r_mem_memread;
    logic              r_mem_memwrite;
    logic              r_mem_memtoreg;
    logic              r_mem_regwrite;
    logic [REG_AW-1:0] r_mem_rd;
    logic              r_wb_memtoreg;
    logic              r_wb_regwrite;
    logic [REG_AW-1:0] r_wb_rd;

    ctrl_decode u_decode (
        .valid   (id_valid),
        .opcode  (id_opcode),
        .funct7  (id_funct7),
        .ctrl    (w_id_ctrl),
        .md      (w_id_md),
        .use_rs1 (w_use_rs1),
        .use_rs2 (w_use_rs2)
    );

    assign w_id_rd = w_id_ctrl.regwrite ? id_rd : '0;

    // Usage flags are already zero for an invalid ID slot.
    assign w_load_use = r_ex_ctrl.memread && (r_ex_rd != '0) &&
                        ((w_use_rs1 && (id_rs1 == r_ex_rd)) ||
                         (w_use_rs2 && (id_rs2 == r_ex_rd)));

    assign w_ex_bubble = ex_redirect || w_load_use;
    assign stall_id    = mem_stall || w_md_busy || (w_load_use && !ex_redirect);
    assign id_flush    = w_id_ctrl.jal || w_id_ctrl.jalr;

`ifdef CTRL_MULDIV_EN
    localparam int CNT_W = $clog2(MD_LATENCY);

    logic [CNT_W-1:0] r_md_cnt;

    assign w_md_busy = (r_md_cnt != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_md_cnt <= '0;
        end else if (!mem_stall) begin
            if (w_md_busy) begin
                r_md_cnt <= r_md_cnt - 1'b1;
            end else if (!w_ex_bubble && w_id_md) begin
                r_md_cnt <= CNT_W'(MD_LATENCY - 1);
            end
        end
    end
`else
    localparam int c_unused_md_latency = MD_LATENCY;

    assign w_md_busy = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ex_ctrl      <= CTRL_BUBBLE;
            r_ex_md        <= 1'b0;
            r_ex_rd        <= '0;
            r_mem_memread  <= 1'b0;
            r_mem_memwrite <= 1'b0;
            r_mem_memtoreg <= 1'b0;
            r_mem_regwrite <= 1'b0;
            r_mem_rd       <= '0;
            r_wb_memtoreg  <= 1'b0;
            r_wb_regwrite  <= 1'b0;
            r_wb_rd        <= '0;
        end else if (!mem_stall) begin
            r_wb_memtoreg <= r_mem_memtoreg;
            r_wb_regwrite <= r_mem_regwrite;
            r_wb_rd       <= r_mem_rd;
            if (w_md_busy) begin
                // EX is occupied by mul/div: hold ID/EX, feed MEM a bubble.
                r_mem_memread  <= 1'b0;
                r_mem_memwrite <= 1'b0;
                r_mem_memtoreg <= 1'b0;
                r_mem_regwrite <= 1'b0;
                r_mem_rd       <= '0;
            end else begin
                r_mem_memread  <= r_ex_ctrl.memread;
                r_mem_memwrite <= r_ex_ctrl.memwrite;
                r_mem_memtoreg <= r_ex_ctrl.memtoreg;
                r_mem_regwrite <= r_ex_ctrl.regwrite;
                r_mem_rd       <= r_ex_rd;
                if (w_ex_bubble) begin
                    r_ex_ctrl <= CTRL_BUBBLE;
                    r_ex_md   <= 1'b0;
                    r_ex_rd   <= '0;
                end else begin
                    r_ex_ctrl <= w_id_ctrl;
                    r_ex_md   <= w_id_md;
                    r_ex_rd   <= w_id_rd;
                end
            end
        end
    end

    assign ex_jalr      = r_ex_ctrl.jalr;
    assign ex_jal       = r_ex_ctrl.jal;
    assign ex_branch    = r_ex_ctrl.branch;
    assign ex_memread   = r_ex_ctrl.memread;
    assign ex_memtoreg  = r_ex_ctrl.memtoreg;
    assign ex_memwrite  = r_ex_ctrl.memwrite;
    assign ex_alusrc    = r_ex_ctrl.alusrc;
    assign ex_regwrite  = r_ex_ctrl.regwrite;
    assign ex_aluop     = r_ex_ctrl.aluop;
    assign ex_md        = r_ex_md;
    assign ex_rd        = r_ex_rd;
    assign mem_memread  = r_mem_memread;
    assign mem_memwrite = r_mem_memwrite;
    assign mem_memtoreg = r_mem_memtoreg;
    assign mem_regwrite = r_mem_regwrite;
    assign mem_rd       = r_mem_rd;
    assign wb_memtoreg  = r_wb_memtoreg;
    assign wb_regwrite  = r_wb_regwrite;
    assign wb_rd        = r_wb_rd;
    assign md_busy      = w_md_busy;

endmodule

`default_nettype wire

// File: doc/ctrl_pipe.md
# ctrl_pipe

Pipelined control unit for the RV32I core. Decodes the ID-stage opcode into the control bundle and carries that bundle through the EX, MEM and WB pipeline registers. It detects load-use hazards, inserts bubbles, and applies redirect flushes and memory-stall freezes. It replaces the stand-alone combinational decoder; the datapath consumes the per-stage control outputs directly.

## Interface
- `REG_AW`, 5: register-index width.
- `MD_LATENCY`, 32: EX occupancy in cycles of a mul/div op (≥2; used only with the mul/div feature).
- `clk` in 1: clock.
- `rst_n` in 1: synchronous, active-low reset.
- `id_valid` in 1: ID holds a real instruction.
- `id_opcode` in 7: ID opcode.
- `id_funct7` in 7: ID funct7.
- `id_rs1`, `id_rs2`, `id_rd` in REG_AW: ID register indices.
- `ex_redirect` in 1: branch taken / JAL / JALR resolved in EX; kill the ID instruction.
- `mem_stall` in 1: data memory not ready; freeze the whole pipe.
- `stall_id` out 1: hold PC and IF/ID (combinational).
- `id_flush` out 1: ID holds JAL/JALR (combinational; gated by id_valid).
- `ex_jalr`, `ex_jal`, `ex_branch`, `ex_memread`, `ex_memtoreg`, `ex_memwrite`, `ex_alusrc`, `ex_regwrite` out 1 each: EX control.
- `ex_aluop` out 2: EX ALU class.
- `ex_md` out 1: EX op is mul/div.
- `ex_rd` out REG_AW: EX destination.
- `mem_memread`, `mem_memwrite`, `mem_memtoreg`, `mem_regwrite` out 1 each; `mem_rd` out REG_AW: MEM-stage control and destination.
- `wb_memtoreg`, `wb_regwrite` out 1 each; `wb_rd` out REG_AW: WB-stage control and destination.
- `md_busy` out 1: mul/div occupying EX.

## Operation
- Decode table (opcode → jalr, jal, branch, memread, memtoreg, memwrite, alusrc, regwrite, aluop):
  - R 0110011 → 0,0,0,0,0,0,0,1,00
  - I 0010011 → 0,0,0,0,0,0,1,1,01
  - LOAD 0000011 → 0,0,0,1,1,0,1,1,10
  - STORE 0100011 → 0,0,0,0,0,1,1,0,10
  - B 1100011 → 0,0,1,0,0,0,0,0,00
  - JAL 1101111 → 0,1,0,0,0,0,0,1,11
  - JALR 1100111 → 1,0,0,0,0,0,1,1,11
  - Any other opcode, or id_valid=0 → all zero (bubble).
- Register usage:
  - rs1 is used by R, I, LOAD, STORE, B and JALR.
  - rs2 is used by R, STORE and B.
- Load-use hazard: `ex_memread=1`, `ex_rd≠0`, and ex_rd matches a used rs of a valid ID instruction.
  - Assert `stall_id`.
  - EX loads a bubble next cycle.
- Stage advance, in priority order:
  1. `mem_stall`: all stage registers hold; `stall_id=1`.
  2. `md_busy` (feature on): ID and EX hold; MEM loads a bubble; `stall_id=1`.
  3. `ex_redirect`: EX loads a bubble. `stall_id=0`; IF/ID flush is external. Redirect overrides load-use.
  4. Load-use: see above.
  5. Otherwise ID→EX→MEM→WB advance.
- A bubble means every control bit is 0 and rd is 0.
- rd is zeroed in a stage whenever that stage's regwrite is 0.

## Timing
- The decode-to-EX, EX-to-MEM and MEM-to-WB steps each take one cycle. An instruction in ID at cycle n appears on WB outputs at n+3 when no stalls occur.
- `stall_id` and `id_flush` are combinational from the current inputs and state, with no registered delay.
- Reset (`rst_n=0` at a rising edge): every registered output is 0, `md_busy=0`, and the mul/div counter is 0. Reset overrides all stall and hold conditions, including during a mul/div op.
- Back-to-back loads with dependents: each load-use pair costs exactly one bubble.
- `mem_stall` during a load-use stall: the hazard is re-evaluated every cycle, and exactly one bubble is inserted in total.

## Configuration
- `CTRL_MULDIV_EN` defined:
  - An R-type op with `id_funct7=0000001` decodes with `ex_md=1` and aluop 00.
  - On entry to EX, a counter loads MD_LATENCY−1.
  - `md_busy` is high while the counter is nonzero. The counter decrements each cycle unless `mem_stall` is high.
  - When the counter reaches 0, the op advances to MEM.
  - `ex_redirect` has no effect while `md_busy` is high.
- `CTRL_MULDIV_EN` undefined:
  - funct7 is ignored.
  - `ex_md` and `md_busy` are tied to 0.
  - No counter is present.

## Structure
- Shared package `ctrl_pkg` contains:
  - the opcode localparams;
  - the aluop encodings;
  - a packed `ctrl_t` struct holding the nine decode fields;
  - the `CTRL_BUBBLE` constant.
- Sub-module `ctrl_decode` is the combinational opcode→`ctrl_t` table plus the rs1/rs2 usage flags.
- Hazard logic, stage registers and the mul/div counter stay in `ctrl_pipe`.

## Test plan
- Reset: drive `rst_n=0` for 2 cycles with a valid R-type in ID → all outputs 0. After release, the R-type reaches WB three cycles later with `wb_regwrite=1`.
- Load-use: LOAD to x5, then ADD x6,x5,x7 → `stall_id=1` for one cycle, and EX holds a bubble (all 0) for that cycle. Also issue a load to x0 followed by a consumer of x0 → no stall.
- Redirect: `ex_redirect=1` with a STORE in ID → next cycle `ex_memwrite=0`, and the store never reaches MEM.
- Memory stall: with LOAD in MEM, assert `mem_stall` for 3 cycles → all stage outputs are frozen for those 3 cycles and `stall_id=1`.
- JAL decode: JAL in ID → `id_flush=1`. Next cycle `ex_jal=1`, `ex_regwrite=1`, `ex_aluop=11`.
- `CTRL_MULDIV_EN` with MD_LATENCY=4: MUL in EX → `md_busy` is high for 3 cycles, MEM receives bubbles, and the MUL reaches MEM on the 4th cycle.
